// File: rtl/register_file.sv
// rtl/register_file.sv - 32-entry general-purpose register file, two registered read ports, one write port
module register_file #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset_l,
  input  logic              read_l,
  input  logic [ADDR_W-1:0] scr1,
  input  logic [ADDR_W-1:0] scr2,
  input  logic [ADDR_W-1:0] dest,
  input  logic [WIDTH-1:0]  writeIn,
  output logic [WIDTH-1:0]  readOut1,
  output logic [WIDTH-1:0]  readOut2
);

  localparam int DEPTH = 1 << ADDR_W;

  // Register 0 is an ordinary storage location, not a hardwired zero.
  logic [WIDTH-1:0] regs [DEPTH];

  // One-hot write enable per entry; only active in a write-mode cycle.
  logic [DEPTH-1:0] wr_sel;

  // Decode the destination address into per-entry write strobes.
  always_comb begin
    wr_sel = '0;
    if (read_l) begin
      wr_sel[dest] = 1'b1;
    end
  end

  // Storage array: cleared asynchronously, written only in write-mode cycles.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_sel[i]) begin
          regs[i] <= writeIn;
        end
      end
    end
  end

  // Registered read ports: update only in read-mode cycles, otherwise hold.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      readOut1 <= '0;
      readOut2 <= '0;
    end else if (!read_l) begin
      readOut1 <= regs[scr1];
      readOut2 <= regs[scr2];
    end
  end

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed self-checking bench for register_file
module tb_register_file;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              reset_l;
  logic              read_l;
  logic [ADDR_W-1:0] scr1;
  logic [ADDR_W-1:0] scr2;
  logic [ADDR_W-1:0] dest;
  logic [WIDTH-1:0]  writeIn;
  logic [WIDTH-1:0]  readOut1;
  logic [WIDTH-1:0]  readOut2;

  int tests;
  int failed;

  register_file #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .reset_l  (reset_l),
    .read_l   (read_l),
    .scr1     (scr1),
    .scr2     (scr2),
    .dest     (dest),
    .writeIn  (writeIn),
    .readOut1 (readOut1),
    .readOut2 (readOut2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    @(negedge clk);
    read_l  = 1'b1;
    dest    = a;
    writeIn = d;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
    @(negedge clk);
    read_l = 1'b0;
    scr1   = a1;
    scr2   = a2;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] pattern(input int i);
    logic [WIDTH-1:0] v;
    v = WIDTH'(i) * 32'h0101_0101;
    return v ^ 32'hA5A5_0000;
  endfunction

  initial begin
    tests   = 0;
    failed  = 0;
    reset_l = 1'b0;
    read_l  = 1'b0;
    scr1    = '0;
    scr2    = '0;
    dest    = '0;
    writeIn = '0;

    // Reset state
    #1;
    check("reset_out1", readOut1, 32'h0);
    check("reset_out2", readOut2, 32'h0);
    @(negedge clk);
    reset_l = 1'b1;
    rd(5'd0, 5'd4);
    check("post_reset_rd1", readOut1, 32'h0);
    check("post_reset_rd2", readOut2, 32'h0);

    // Write and read back registers 0 and 4
    wr(5'd0, 32'h0000_0001);
    wr(5'd4, 32'hFFFF_FFFF);
    rd(5'd0, 5'd4);
    check("r0_read", readOut1, 32'h0000_0001);
    check("r4_read", readOut2, 32'hFFFF_FFFF);

    // Outputs hold during a write cycle
    wr(5'd4, 32'h1234_5678);
    check("hold_out1", readOut1, 32'h0000_0001);
    check("hold_out2", readOut2, 32'hFFFF_FFFF);
    rd(5'd0, 5'd4);
    check("r4_rewrite", readOut2, 32'h1234_5678);
    check("r0_unchanged", readOut1, 32'h0000_0001);

    // Reset clears contents asynchronously
    wr(5'd4, 32'hFFFF_FFFF);
    rd(5'd0, 5'd4);
    check("preload_r0", readOut1, 32'h0000_0001);
    check("preload_r4", readOut2, 32'hFFFF_FFFF);
    @(negedge clk);
    #2 reset_l = 1'b0;
    #1;
    check("async_clr_out1", readOut1, 32'h0);
    check("async_clr_out2", readOut2, 32'h0);
    #1 reset_l = 1'b1;
    rd(5'd0, 5'd4);
    check("cleared_r0", readOut1, 32'h0);
    check("cleared_r4", readOut2, 32'h0);

    // Registers 14 and 31
    wr(5'd14, 32'hDEAD_BEEF);
    rd(5'd14, 5'd31);
    check("r14_read", readOut1, 32'hDEAD_BEEF);
    check("r31_read", readOut2, 32'h0);

    // Same address on both ports
    rd(5'd14, 5'd14);
    check("same_addr1", readOut1, 32'hDEAD_BEEF);
    check("same_addr2", readOut2, 32'hDEAD_BEEF);

    // Write attempted while reset is held is ignored; reads in reset ignored too
    @(negedge clk);
    reset_l = 1'b0;
    read_l  = 1'b1;
    dest    = 5'd5;
    writeIn = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    read_l = 1'b0;
    scr1   = 5'd5;
    scr2   = 5'd14;
    @(posedge clk);
    #1;
    check("in_reset_out1", readOut1, 32'h0);
    check("in_reset_out2", readOut2, 32'h0);
    @(negedge clk);
    reset_l = 1'b1;
    rd(5'd5, 5'd14);
    check("no_write_in_reset", readOut1, 32'h0);
    check("r14_cleared", readOut2, 32'h0);

    // Every address holds its own value (decoder coverage)
    for (int i = 0; i < 32; i++) begin
      wr(ADDR_W'(i), pattern(i));
    end
    for (int i = 0; i < 32; i++) begin
      rd(ADDR_W'(i), ADDR_W'(31 - i));
      check("walk_port1", readOut1, pattern(i));
      check("walk_port2", readOut2, pattern(31 - i));
    end

    // First edge after reset release performs a write
    @(negedge clk);
    reset_l = 1'b0;
    #1;
    check("rst2_out1", readOut1, 32'h0);
    @(negedge clk);
    reset_l = 1'b1;
    read_l  = 1'b1;
    dest    = 5'd31;
    writeIn = 32'h0BAD_CAFE;
    @(posedge clk);
    #1;
    check("rst_rel_hold", readOut1, 32'h0);
    rd(5'd31, 5'd1);
    check("rst_rel_write", readOut1, 32'h0BAD_CAFE);
    check("rst_rel_other", readOut2, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
